// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode/execute RAW interlock using a per-register countdown scoreboard.
// Ports: Clock/Reset_n (async active-low); decode-side current_address, valid,
// global_branch_taken, operation, inmediate, destination, read0..2, use_read0..2,
// writes_dest, branch_taken, link, from_register, ram_enable_write/read;
// outputs stall (combinational), overwrite_address, out_valid, out_* registered
// copies of the decode fields, deadlock (sticky watchdog).
// Optional macro HAZARD_FORWARD_EN: the last pending cycle is covered by the
// execute bypass, so a source is only busy while its countdown exceeds 1.
module hazard_scoreboard #(
  parameter int R_ADDR_SIZE    = 5,
  parameter int OP_SIZE        = 6,
  parameter int INMEDIATE_SIZE = 16,
  parameter int DEPTH          = 3,
  parameter int MAX_STALL      = 15
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [31:0]               current_address,
  input  logic                      valid,
  input  logic                      global_branch_taken,
  input  logic [OP_SIZE-1:0]        operation,
  input  logic [INMEDIATE_SIZE-1:0] inmediate,
  input  logic [R_ADDR_SIZE-1:0]    destination,
  input  logic [R_ADDR_SIZE-1:0]    read0,
  input  logic [R_ADDR_SIZE-1:0]    read1,
  input  logic [R_ADDR_SIZE-1:0]    read2,
  input  logic                      use_read0,
  input  logic                      use_read1,
  input  logic                      use_read2,
  input  logic                      writes_dest,
  input  logic                      branch_taken,
  input  logic                      link,
  input  logic                      from_register,
  input  logic                      ram_enable_write,
  input  logic                      ram_enable_read,
  output logic                      stall,
  output logic [31:0]               overwrite_address,
  output logic                      out_valid,
  output logic [OP_SIZE-1:0]        out_operation,
  output logic [INMEDIATE_SIZE-1:0] out_inmediate,
  output logic [R_ADDR_SIZE-1:0]    out_destination,
  output logic [R_ADDR_SIZE-1:0]    out_read0,
  output logic [R_ADDR_SIZE-1:0]    out_read1,
  output logic [R_ADDR_SIZE-1:0]    out_read2,
  output logic                      out_branch_taken,
  output logic                      out_link,
  output logic                      out_from_register,
  output logic                      out_ram_enable_write,
  output logic                      out_ram_enable_read,
  output logic                      deadlock
);
  localparam int NREG = 1 << R_ADDR_SIZE;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(MAX_STALL + 1);
`ifdef HAZARD_FORWARD_EN
  localparam logic [CW-1:0] LIM = CW'(1);
`else
  localparam logic [CW-1:0] LIM = CW'(0);
`endif
  logic [CW-1:0] pend [NREG];
  logic [SW-1:0] stall_cnt;
  logic [2:0]    busy;
  logic          issue;
  always_comb begin
    busy[0] = use_read0 & (read0 != '0) & (pend[read0] > LIM);
    busy[1] = use_read1 & (read1 != '0) & (pend[read1] > LIM);
    busy[2] = use_read2 & (read2 != '0) & (pend[read2] > LIM);
    stall   = valid & (|busy);
    issue   = valid & ~stall & ~global_branch_taken;
  end
  // Entry 0 is only ever written by reset, so r0 never looks pending.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        pend[i] <= (issue & writes_dest & (destination == R_ADDR_SIZE'(i))) ? CW'(DEPTH) :
                   (pend[i] != '0) ? pend[i] - CW'(1) : pend[i];
    end
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt         <= '0;
      deadlock          <= 1'b0;
      overwrite_address <= '0;
    end else begin
      stall_cnt         <= (global_branch_taken | ~stall) ? '0 :
                           (stall_cnt == SW'(MAX_STALL)) ? stall_cnt : stall_cnt + SW'(1);
      deadlock          <= deadlock | (stall & (stall_cnt == SW'(MAX_STALL)));
      overwrite_address <= stall ? overwrite_address : current_address;
    end
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid            <= 1'b0;
      out_operation        <= '0;
      out_inmediate        <= '0;
      out_destination      <= '0;
      out_read0            <= '0;
      out_read1            <= '0;
      out_read2            <= '0;
      out_branch_taken     <= 1'b0;
      out_link             <= 1'b0;
      out_from_register    <= 1'b0;
      out_ram_enable_write <= 1'b0;
      out_ram_enable_read  <= 1'b0;
    end else begin
      out_valid            <= issue;
      out_operation        <= issue ? operation : '0;
      out_inmediate        <= issue ? inmediate : '0;
      out_destination      <= issue ? destination : '0;
      out_read0            <= issue ? read0 : '0;
      out_read1            <= issue ? read1 : '0;
      out_read2            <= issue ? read2 : '0;
      out_branch_taken     <= issue & branch_taken;
      out_link             <= issue & link;
      out_from_register    <= issue & from_register;
      out_ram_enable_write <= issue & ram_enable_write;
      out_ram_enable_read  <= issue & ram_enable_read;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed table, hand sequences and random stimulus against an issue-time model.
module tb_hazard_scoreboard;
  localparam int D    = 3;
  localparam int MAXS = 15;
`ifdef HAZARD_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic        Reset_n;
  logic [31:0] current_address;
  logic        valid, global_branch_taken;
  logic [5:0]  operation;
  logic [15:0] inmediate;
  logic [4:0]  destination, read0, read1, read2;
  logic        use_read0, use_read1, use_read2, writes_dest;
  logic        branch_taken, link, from_register, ram_enable_write, ram_enable_read;
  logic        stall, out_valid, deadlock;
  logic [31:0] overwrite_address;
  logic [5:0]  out_operation;
  logic [15:0] out_inmediate;
  logic [4:0]  out_destination, out_read0, out_read1, out_read2;
  logic        out_branch_taken, out_link, out_from_register, out_ram_enable_write, out_ram_enable_read;
  logic [46:0] in_bus, out_bus;
  assign in_bus  = {operation, inmediate, destination, read0, read1, read2,
                    branch_taken, link, from_register, ram_enable_write, ram_enable_read};
  assign out_bus = {out_operation, out_inmediate, out_destination, out_read0, out_read1, out_read2,
                    out_branch_taken, out_link, out_from_register, out_ram_enable_write, out_ram_enable_read};
  hazard_scoreboard #(.DEPTH(D), .MAX_STALL(MAXS)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .current_address(current_address), .valid(valid),
    .global_branch_taken(global_branch_taken), .operation(operation), .inmediate(inmediate),
    .destination(destination), .read0(read0), .read1(read1), .read2(read2),
    .use_read0(use_read0), .use_read1(use_read1), .use_read2(use_read2), .writes_dest(writes_dest),
    .branch_taken(branch_taken), .link(link), .from_register(from_register),
    .ram_enable_write(ram_enable_write), .ram_enable_read(ram_enable_read),
    .stall(stall), .overwrite_address(overwrite_address), .out_valid(out_valid),
    .out_operation(out_operation), .out_inmediate(out_inmediate), .out_destination(out_destination),
    .out_read0(out_read0), .out_read1(out_read1), .out_read2(out_read2),
    .out_branch_taken(out_branch_taken), .out_link(out_link), .out_from_register(out_from_register),
    .out_ram_enable_write(out_ram_enable_write), .out_ram_enable_read(out_ram_enable_read),
    .deadlock(deadlock));
  // Small watchdog instance: 7-cycle stall against a limit of 4, so the flag must latch.
  logic        w_valid, w_use0, w_wd;
  logic [4:0]  w_dest, w_read0;
  logic        w_stall, w_ov, w_dl, w_b, w_l, w_f, w_we, w_re;
  logic [31:0] w_oa;
  logic [5:0]  w_op;
  logic [15:0] w_im;
  logic [4:0]  w_d, w_r0, w_r1, w_r2;
  hazard_scoreboard #(.DEPTH(7), .MAX_STALL(4)) wdut (
    .Clock(Clock), .Reset_n(Reset_n), .current_address(32'h0), .valid(w_valid),
    .global_branch_taken(1'b0), .operation(6'h0), .inmediate(16'h0),
    .destination(w_dest), .read0(w_read0), .read1(5'h0), .read2(5'h0),
    .use_read0(w_use0), .use_read1(1'b0), .use_read2(1'b0), .writes_dest(w_wd),
    .branch_taken(1'b0), .link(1'b0), .from_register(1'b0),
    .ram_enable_write(1'b0), .ram_enable_read(1'b0),
    .stall(w_stall), .overwrite_address(w_oa), .out_valid(w_ov),
    .out_operation(w_op), .out_inmediate(w_im), .out_destination(w_d),
    .out_read0(w_r0), .out_read1(w_r1), .out_read2(w_r2),
    .out_branch_taken(w_b), .out_link(w_l), .out_from_register(w_f),
    .out_ram_enable_write(w_we), .out_ram_enable_read(w_re), .deadlock(w_dl));
  int checks = 0, errors = 0;
  // Model: a register may be read from edge number safe_edge[r] onward.
  int safe_edge [32];
  int edge_n, m_cnt;
  logic [31:0] m_addr;
  logic m_dl;
  typedef struct packed {
    logic v, fl;
    logic [4:0] d, a, b, c;
    logic u0, u1, u2, wd, st, iss;
  } vec_t;
  vec_t tbl [21];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic busy(input logic u, input logic [4:0] r, input int n);
    return u && r != 5'd0 && n < safe_edge[r];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) safe_edge[i] = 0;
    edge_n = 0; m_cnt = 0; m_addr = '0; m_dl = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_bus"}, 64'(out_bus), 64'd0);
    chk({tag, "_overwrite_address"}, 64'(overwrite_address), 64'd0);
    chk({tag, "_deadlock"}, 64'(deadlock), 64'd0);
  endtask
  task automatic pre_edge(output logic s);
    int n;
    n = edge_n + 1;
    #1;
    s = valid & (busy(use_read0, read0, n) | busy(use_read1, read1, n) | busy(use_read2, read2, n));
    chk("stall", 64'(stall), 64'(s));
  endtask
  task automatic post_edge(input logic s);
    logic iss, fl, wd;
    logic [46:0] ib;
    logic [31:0] pc;
    logic [4:0] dst;
    iss = valid & ~s & ~global_branch_taken;
    fl = global_branch_taken; wd = writes_dest; ib = in_bus; pc = current_address; dst = destination;
    @(posedge Clock);
    edge_n++;
    if (iss && wd && dst != 5'd0) safe_edge[dst] = edge_n + D + 1 - FWD;
    m_dl = m_dl | (s && m_cnt == MAXS);
    m_cnt = (fl || !s) ? 0 : (m_cnt == MAXS ? MAXS : m_cnt + 1);
    if (!s) m_addr = pc;
    #1;
    chk("out_valid", 64'(out_valid), 64'(iss));
    chk("out_bus", 64'(out_bus), iss ? 64'(ib) : 64'd0);
    chk("overwrite_address", 64'(overwrite_address), 64'(m_addr));
    chk("deadlock", 64'(deadlock), 64'(m_dl));
  endtask
  task automatic step();
    logic s;
    pre_edge(s);
    post_edge(s);
  endtask
  task automatic set_instr(input logic v, input logic fl, input logic [4:0] d, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] c, input logic u0, input logic u1,
                           input logic u2, input logic wd, input logic [31:0] pc);
    valid = v; global_branch_taken = fl; destination = d; read0 = a; read1 = b; read2 = c;
    use_read0 = u0; use_read1 = u1; use_read2 = u2; writes_dest = wd; current_address = pc;
  endtask
  function automatic vec_t mk(input int v, input int fl, input int d, input int a, input int b,
                              input int c, input int u0, input int u1, input int u2, input int wd,
                              input int st, input int iss);
    vec_t t;
    t.v = v[0]; t.fl = fl[0]; t.d = 5'(d); t.a = 5'(a); t.b = 5'(b); t.c = 5'(c);
    t.u0 = u0[0]; t.u1 = u1[0]; t.u2 = u2[0]; t.wd = wd[0]; t.st = st[0]; t.iss = iss[0];
    return t;
  endfunction
  initial begin
    logic s;
    tbl[0]  = mk(1,0, 5,1,0,0, 1,0,0,1, 0,1);
    tbl[1]  = mk(1,0, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[2]  = mk(1,0, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[3]  = mk(1,0, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[4]  = mk(1,0, 6,5,1,0, 1,1,0,1, 0,1);
    tbl[5]  = mk(1,0, 5,1,0,0, 1,0,0,1, 0,1);
    tbl[6]  = mk(1,0, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[7]  = mk(1,1, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[8]  = mk(1,0, 6,5,1,0, 1,1,0,1, 1,0);
    tbl[9]  = mk(1,0, 6,5,1,0, 1,1,0,1, 0,1);
    tbl[10] = mk(1,0, 5,1,0,0, 1,0,0,1, 0,1);
    tbl[11] = mk(1,0, 9,1,5,0, 1,0,0,1, 0,1);
    tbl[12] = mk(0,0, 5,5,0,0, 1,0,0,0, 0,0);
    tbl[13] = mk(1,0,10,0,0,5, 0,0,1,1, 1,0);
    tbl[14] = mk(1,0,10,0,0,5, 0,0,1,1, 0,1);
    tbl[15] = mk(1,0, 7,7,0,0, 1,0,0,1, 0,1);
    tbl[16] = mk(1,0, 8,7,0,0, 1,0,0,1, 1,0);
    tbl[17] = mk(1,0, 0,0,0,0, 1,0,0,1, 0,1);
    tbl[18] = mk(1,0,11,0,0,0, 1,1,1,1, 0,1);
    tbl[19] = mk(1,1,12,0,0,0, 0,0,0,1, 0,0);
    tbl[20] = mk(1,0,13,12,0,0, 1,0,0,1, 0,1);
    Reset_n = 1'b0;
    set_instr(0,0,0,0,0,0,0,0,0,0,32'h0);
    operation = '0; inmediate = '0;
    branch_taken = 0; link = 0; from_register = 0; ram_enable_write = 0; ram_enable_read = 0;
    w_valid = 0; w_use0 = 0; w_wd = 0; w_dest = '0; w_read0 = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #2;
    chk_all_zero("reset");
    Reset_n = 1'b1;
`ifndef HAZARD_FORWARD_EN
    for (int i = 0; i < 21; i++) begin
      set_instr(tbl[i].v, tbl[i].fl, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].c,
                tbl[i].u0, tbl[i].u1, tbl[i].u2, tbl[i].wd, 32'h100 + 32'(4 * i));
      operation = 6'(i); inmediate = 16'(i * 3); link = i[0]; ram_enable_read = i[1];
      pre_edge(s);
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].st));
      post_edge(s);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].iss));
      chk($sformatf("tbl%0d_dest", i), 64'(out_destination), tbl[i].iss ? 64'(tbl[i].d) : 64'd0);
    end
`endif
    for (int k = 0; k < 400; k++) begin
      set_instr($urandom_range(0, 99) < 85, $urandom_range(0, 9) == 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom);
      operation = 6'($urandom); inmediate = 16'($urandom);
      {branch_taken, link, from_register, ram_enable_write, ram_enable_read} = 5'($urandom);
      step();
    end
    set_instr(1,0,5,1,0,0,1,0,0,1,32'h200);
    step();
    set_instr(1,0,6,5,0,0,1,0,0,1,32'h204);
    step();
    #1;
    Reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    #1 Reset_n = 1'b1;
    set_instr(1,0,3,5,1,0,1,1,0,1,32'h300);
    pre_edge(s);
    chk("post_reset_stall", 64'(stall), 64'd0);
    post_edge(s);
    chk("post_reset_issue", 64'(out_destination), 64'd3);
    set_instr(0,0,0,0,0,0,0,0,0,0,32'h0);
    w_valid = 1; w_dest = 5'd5; w_read0 = 5'd1; w_use0 = 1; w_wd = 1;
    @(posedge Clock); #1;
    w_dest = 5'd6; w_read0 = 5'd5;
    for (int k = 1; k <= 7; k++) begin
      #1 chk($sformatf("wd_stall%0d", k), 64'(w_stall), 64'd1);
      @(posedge Clock); #1;
      chk($sformatf("wd_deadlock%0d", k), 64'(w_dl), 64'(k >= 5));
    end
    #1 chk("wd_stall_clear", 64'(w_stall), 64'd0);
    @(posedge Clock); #1;
    w_valid = 0;
    repeat (3) @(posedge Clock);
    #1 chk("wd_sticky", 64'(w_dl), 64'd1);
    Reset_n = 1'b0;
    #1;
    chk("wd_reset", 64'(w_dl), 64'd0);
    chk_all_zero("final_reset");
    #3 Reset_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
